// File: rtl/reorder_buffer_if.sv
// Decoder / CDB / register-file bundle of the reorder buffer.
// master = surrounding pipeline, slave = reorder buffer.
interface reorder_buffer_if #(
  parameter int ROB_BIT = 3
);
  // Issue handshake: a transfer happens on the edge where issue_valid && issue_ready.
  // issue_ready never depends on issue_valid.
  logic               issue_valid;
  logic [1:0]         issue_type;
  logic [4:0]         issue_rd;
  logic               issue_ready;
  logic [ROB_BIT-1:0] issue_entry;

  logic               rob_issue_reg;
  logic [4:0]         issue_reg_id;
  logic [ROB_BIT-1:0] issue_rob_entry;

  logic               wb_valid;
  logic [ROB_BIT-1:0] wb_entry;
  logic [31:0]        wb_value;
  logic               wb_mispredict;
  logic [31:0]        wb_target;

  logic [ROB_BIT-1:0] get_rob_entry1;
  logic [ROB_BIT-1:0] get_rob_entry2;
  logic               ready1;
  logic               ready2;
  logic [31:0]        value1;
  logic [31:0]        value2;

  logic               rob_commit_reg;
  logic [4:0]         commit_reg_id;
  logic [31:0]        commit_reg_data;
  logic [ROB_BIT-1:0] commit_rob_entry;
  logic               commit_store;
  logic               rob_clear_up;
  logic [31:0]        clear_pc;
  logic [ROB_BIT-1:0] head_entry;

  modport master (
    output issue_valid, issue_type, issue_rd,
    output wb_valid, wb_entry, wb_value, wb_mispredict, wb_target,
    output get_rob_entry1, get_rob_entry2,
    input  issue_ready, issue_entry,
    input  rob_issue_reg, issue_reg_id, issue_rob_entry,
    input  ready1, ready2, value1, value2,
    input  rob_commit_reg, commit_reg_id, commit_reg_data, commit_rob_entry,
    input  commit_store, rob_clear_up, clear_pc, head_entry
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd,
    input  wb_valid, wb_entry, wb_value, wb_mispredict, wb_target,
    input  get_rob_entry1, get_rob_entry2,
    output issue_ready, issue_entry,
    output rob_issue_reg, issue_reg_id, issue_rob_entry,
    output ready1, ready2, value1, value2,
    output rob_commit_reg, commit_reg_id, commit_reg_data, commit_rob_entry,
    output commit_store, rob_clear_up, clear_pc, head_entry
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback, in-order retire.
// Optional macro ROB_WB_BYPASS_EN forwards a same-cycle CDB result into the lookups.
module reorder_buffer #(
  parameter int ROB_BIT = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  rob
);
  localparam int DEPTH = 1 << ROB_BIT;
  localparam logic [ROB_BIT:0] FULL = (ROB_BIT + 1)'(DEPTH);

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_OTHER  = 2'd3
  } op_t;

  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   done;
  logic [DEPTH-1:0]   mis;
  op_t                typ  [DEPTH];
  logic [4:0]         rd   [DEPTH];
  logic [31:0]        val  [DEPTH];
  logic [31:0]        tgt  [DEPTH];
  logic [ROB_BIT-1:0] head;
  logic [ROB_BIT-1:0] tail;
  logic [ROB_BIT:0]   count;

  logic commit_ok;
  logic flush;
  logic issue_ok;
  logic issue_fire;
  logic wb_hit;

  always_comb begin
    commit_ok  = rdy_in && busy[head] && done[head];
    flush      = commit_ok && (typ[head] == T_BRANCH) && mis[head];
    // A full buffer stays closed even if the head retires this cycle.
    issue_ok   = rdy_in && (count != FULL) && !flush;
    issue_fire = issue_ok && rob.issue_valid;
    wb_hit     = rob.wb_valid && busy[rob.wb_entry];
  end

  always_comb begin
    rob.issue_ready     = issue_ok;
    rob.issue_entry     = tail;
    rob.rob_issue_reg   = issue_fire && (rob.issue_type == T_REG) && (rob.issue_rd != 5'd0);
    rob.issue_reg_id    = rob.issue_rd;
    rob.issue_rob_entry = tail;
    rob.head_entry      = head;

    rob.rob_commit_reg   = 1'b0;
    rob.commit_reg_id    = 5'd0;
    rob.commit_reg_data  = 32'd0;
    rob.commit_rob_entry = '0;
    rob.commit_store     = 1'b0;
    rob.rob_clear_up     = flush;
    rob.clear_pc         = flush ? tgt[head] : 32'd0;
    if (commit_ok) begin
      if ((typ[head] == T_REG) && (rd[head] != 5'd0)) begin
        rob.rob_commit_reg   = 1'b1;
        rob.commit_reg_id    = rd[head];
        rob.commit_reg_data  = val[head];
        rob.commit_rob_entry = head;
      end
      rob.commit_store = (typ[head] == T_STORE);
    end
  end

  always_comb begin
    rob.ready1 = busy[rob.get_rob_entry1] && done[rob.get_rob_entry1];
    rob.value1 = val[rob.get_rob_entry1];
    rob.ready2 = busy[rob.get_rob_entry2] && done[rob.get_rob_entry2];
    rob.value2 = val[rob.get_rob_entry2];
`ifdef ROB_WB_BYPASS_EN
    if (rob.wb_valid && (rob.wb_entry == rob.get_rob_entry1) && busy[rob.get_rob_entry1]) begin
      rob.ready1 = 1'b1;
      rob.value1 = rob.wb_value;
    end
    if (rob.wb_valid && (rob.wb_entry == rob.get_rob_entry2) && busy[rob.get_rob_entry2]) begin
      rob.ready2 = 1'b1;
      rob.value2 = rob.wb_value;
    end
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy  <= '0;
      done  <= '0;
      mis   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        typ[i] <= T_OTHER;
        rd[i]  <= 5'd0;
        val[i] <= 32'd0;
        tgt[i] <= 32'd0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        // Everything younger than the mispredicted branch is discarded.
        busy  <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (wb_hit) begin
          done[rob.wb_entry] <= 1'b1;
          val[rob.wb_entry]  <= rob.wb_value;
          mis[rob.wb_entry]  <= rob.wb_mispredict;
          tgt[rob.wb_entry]  <= rob.wb_target;
        end
        if (commit_ok) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        if (issue_fire) begin
          busy[tail] <= 1'b1;
          done[tail] <= 1'b0;
          mis[tail]  <= 1'b0;
          typ[tail]  <= op_t'(rob.issue_type);
          rd[tail]   <= rob.issue_rd;
          tail       <= tail + 1'b1;
        end
        count <= count + {{ROB_BIT{1'b0}}, issue_fire} - {{ROB_BIT{1'b0}}, commit_ok};
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: program-order queue model plus directed literal checks.
module tb_reorder_buffer;
  localparam int ROB_BIT = 3;
  localparam int DEPTH   = 1 << ROB_BIT;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  reorder_buffer_if #(.ROB_BIT(ROB_BIT)) bus ();

  reorder_buffer #(.ROB_BIT(ROB_BIT)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rob    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // Model: live entries in program order; rob_q[0] is the oldest.
  typedef struct {
    int          idx;
    int          typ;
    int          rd;
    bit          rdy;
    logic [31:0] val;
    bit          mis;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    bit          issue_ready;
    int          tail;
    bit          iss_reg;
    bit          commit_ok;
    bit          flush;
    bit          creg;
    int          cid;
    logic [31:0] cdata;
    int          centry;
    bit          cstore;
    logic [31:0] cpc;
    bit          r1;
    bit          r2;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  ent_t rob_q[$];
  int   m_head = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input int idx);
    for (int k = 0; k < rob_q.size(); k++)
      if (rob_q[k].idx == idx) return k;
    return -1;
  endfunction

  task automatic lookup(input int g, output bit r, output logic [31:0] v);
    int k;
    k = find(g);
    r = 1'b0;
    v = 32'd0;
    if (k >= 0) begin
      r = rob_q[k].rdy;
      v = rob_q[k].val;
`ifdef ROB_WB_BYPASS_EN
      if (bus.wb_valid && (int'(bus.wb_entry) == g)) begin
        r = 1'b1;
        v = bus.wb_value;
      end
`endif
    end
  endtask

  task automatic calc(output exp_t e);
    int n;
    n = rob_q.size();
    e = '{default: 0};
    e.tail      = (m_head + n) % DEPTH;
    e.commit_ok = rdy_in && (n > 0) && rob_q[0].rdy;
    if (e.commit_ok) begin
      e.flush = (rob_q[0].typ == 2) && rob_q[0].mis;
      if (rob_q[0].typ == 0 && rob_q[0].rd != 0) begin
        e.creg   = 1'b1;
        e.cid    = rob_q[0].rd;
        e.cdata  = rob_q[0].val;
        e.centry = rob_q[0].idx;
      end
      e.cstore = (rob_q[0].typ == 1);
      if (e.flush) e.cpc = rob_q[0].tgt;
    end
    e.issue_ready = rdy_in && (n != DEPTH) && !e.flush;
    e.iss_reg = e.issue_ready && bus.issue_valid && (bus.issue_type == 2'd0) && (bus.issue_rd != 5'd0);
    lookup(int'(bus.get_rob_entry1), e.r1, e.v1);
    lookup(int'(bus.get_rob_entry2), e.r2, e.v2);
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (chk_en) begin
      calc(e);
      check("issue_ready", 32'(bus.issue_ready), 32'(e.issue_ready));
      check("issue_entry", 32'(bus.issue_entry), 32'(e.tail));
      check("issue_rob_entry", 32'(bus.issue_rob_entry), 32'(e.tail));
      check("rob_issue_reg", 32'(bus.rob_issue_reg), 32'(e.iss_reg));
      check("issue_reg_id", 32'(bus.issue_reg_id), 32'(bus.issue_rd));
      check("head_entry", 32'(bus.head_entry), 32'(m_head));
      check("rob_commit_reg", 32'(bus.rob_commit_reg), 32'(e.creg));
      check("commit_reg_id", 32'(bus.commit_reg_id), 32'(e.cid));
      check("commit_reg_data", bus.commit_reg_data, e.cdata);
      check("commit_rob_entry", 32'(bus.commit_rob_entry), 32'(e.centry));
      check("commit_store", 32'(bus.commit_store), 32'(e.cstore));
      check("rob_clear_up", 32'(bus.rob_clear_up), 32'(e.flush));
      check("clear_pc", bus.clear_pc, e.cpc);
      check("ready1", 32'(bus.ready1), 32'(e.r1));
      check("ready2", 32'(bus.ready2), 32'(e.r2));
      if (e.r1) check("value1", bus.value1, e.v1);
      if (e.r2) check("value2", bus.value2, e.v2);
    end
  end

  always @(posedge clk_in) begin
    exp_t e;
    int   k;
    if (!rst_in && rdy_in) begin
      calc(e);
      if (e.flush) begin
        rob_q.delete();
        m_head = 0;
      end else begin
        if (bus.wb_valid) begin
          k = find(int'(bus.wb_entry));
          if (k >= 0) begin
            rob_q[k].rdy = 1'b1;
            rob_q[k].val = bus.wb_value;
            rob_q[k].mis = bus.wb_mispredict;
            rob_q[k].tgt = bus.wb_target;
          end
        end
        if (e.commit_ok) begin
          void'(rob_q.pop_front());
          m_head = (m_head + 1) % DEPTH;
        end
        if (bus.issue_valid && e.issue_ready)
          rob_q.push_back('{idx: e.tail, typ: int'(bus.issue_type), rd: int'(bus.issue_rd),
                            rdy: 1'b0, val: 32'd0, mis: 1'b0, tgt: 32'd0});
      end
    end
  end

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_type    = 2'd0;
    bus.issue_rd      = 5'd0;
    bus.wb_valid      = 1'b0;
    bus.wb_entry      = '0;
    bus.wb_value      = 32'd0;
    bus.wb_mispredict = 1'b0;
    bus.wb_target     = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    rob_q.delete();
    m_head = 0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle();
    model_reset();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] r);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_type  = t;
    bus.issue_rd    = r;
  endtask

  task automatic wb(input logic [ROB_BIT-1:0] ent, input logic [31:0] v,
                    input logic m, input logic [31:0] tg);
    idle();
    bus.wb_valid      = 1'b1;
    bus.wb_entry      = ent;
    bus.wb_value      = v;
    bus.wb_mispredict = m;
    bus.wb_target     = tg;
  endtask

  initial begin
    int wb_pct;
    int k;
    idle();
    bus.get_rob_entry1 = '0;
    bus.get_rob_entry2 = '0;
    #1;
    chk_en = 1'b1;

    // Reset values, then a renaming issue.
    @(negedge clk_in);
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_head_entry", 32'(bus.head_entry), 32'd0);
    check("rst_pulses", 32'({bus.rob_issue_reg, bus.rob_commit_reg, bus.commit_store, bus.rob_clear_up}), 32'd0);
    check("rst_ready1", 32'(bus.ready1), 32'd0);
    tick();
    rst_in = 1'b0;
    issue(2'd0, 5'd5);
    @(negedge clk_in);
    check("t1_rob_issue_reg", 32'(bus.rob_issue_reg), 32'd1);
    check("t1_issue_reg_id", 32'(bus.issue_reg_id), 32'd5);
    check("t1_issue_rob_entry", 32'(bus.issue_rob_entry), 32'd0);
    tick();

    // Issue, writeback, commit.
    do_reset();
    issue(2'd0, 5'd3);
    tick();
    wb(3'd0, 32'hDEADBEEF, 1'b0, 32'd0);
    tick();
    idle();
    @(negedge clk_in);
    check("t2_rob_commit_reg", 32'(bus.rob_commit_reg), 32'd1);
    check("t2_commit_reg_id", 32'(bus.commit_reg_id), 32'd3);
    check("t2_commit_reg_data", bus.commit_reg_data, 32'hDEADBEEF);
    check("t2_commit_rob_entry", 32'(bus.commit_rob_entry), 32'd0);
    tick();
    check("t2_head_entry", 32'(bus.head_entry), 32'd1);

    // Full buffer, commit while full, tail wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      issue(2'd3, 5'd0);
      tick();
    end
    idle();
    check("t3_full_ready", 32'(bus.issue_ready), 32'd0);
    wb(3'd0, 32'd1, 1'b0, 32'd0);
    tick();
    idle();
    check("t3_full_commit_ready", 32'(bus.issue_ready), 32'd0);
    tick();
    check("t3_after_commit_ready", 32'(bus.issue_ready), 32'd1);
    check("t3_wrap_entry", 32'(bus.issue_entry), 32'd0);

    // Mispredicted branch flushes younger entries.
    do_reset();
    issue(2'd3, 5'd0); tick();
    issue(2'd3, 5'd0); tick();
    issue(2'd2, 5'd0); tick();
    issue(2'd0, 5'd7); tick();
    issue(2'd0, 5'd8); tick();
    wb(3'd3, 32'h33, 1'b0, 32'd0); tick();
    wb(3'd0, 32'h10, 1'b0, 32'd0); tick();
    wb(3'd1, 32'h11, 1'b0, 32'd0); tick();
    wb(3'd2, 32'h22, 1'b1, 32'h100); tick();
    idle();
    bus.get_rob_entry1 = 3'd3;
    bus.get_rob_entry2 = 3'd4;
    @(negedge clk_in);
    check("t4_clear_up", 32'(bus.rob_clear_up), 32'd1);
    check("t4_clear_pc", bus.clear_pc, 32'h100);
    check("t4_pre_ready1", 32'(bus.ready1), 32'd1);
    check("t4_flush_blocks_issue", 32'(bus.issue_ready), 32'd0);
    tick();
    check("t4_head_entry", 32'(bus.head_entry), 32'd0);
    check("t4_issue_entry", 32'(bus.issue_entry), 32'd0);
    check("t4_ready1", 32'(bus.ready1), 32'd0);
    check("t4_ready2", 32'(bus.ready2), 32'd0);

    // Out-of-order writeback, in-order retire.
    do_reset();
    issue(2'd0, 5'd1); tick();
    issue(2'd0, 5'd2); tick();
    wb(3'd1, 32'd11, 1'b0, 32'd0); tick();
    idle();
    @(negedge clk_in);
    check("t5_no_commit", 32'(bus.rob_commit_reg), 32'd0);
    tick();
    wb(3'd0, 32'd10, 1'b0, 32'd0); tick();
    idle();
    @(negedge clk_in);
    check("t5_commit0_entry", 32'(bus.commit_rob_entry), 32'd0);
    check("t5_commit0_data", bus.commit_reg_data, 32'd10);
    tick();
    @(negedge clk_in);
    check("t5_commit1_entry", 32'(bus.commit_rob_entry), 32'd1);
    check("t5_commit1_data", bus.commit_reg_data, 32'd11);
    tick();

    // Lookup of the entry being written back.
    do_reset();
    issue(2'd0, 5'd4); tick();
    wb(3'd0, 32'h55, 1'b0, 32'd0);
    bus.get_rob_entry1 = 3'd0;
    @(negedge clk_in);
`ifdef ROB_WB_BYPASS_EN
    check("t6_bypass_ready1", 32'(bus.ready1), 32'd1);
`else
    check("t6_nobypass_ready1", 32'(bus.ready1), 32'd0);
`endif
    tick();
    idle();
    @(negedge clk_in);
    check("t6_next_ready1", 32'(bus.ready1), 32'd1);
    check("t6_next_value1", bus.value1, 32'h55);
    tick();

    // Randomized traffic with a reset in the middle.
    do_reset();
    wb_pct = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 300 == 0) wb_pct = $urandom_range(10, 90);
      rdy_in            = ($urandom_range(0, 9) != 0);
      bus.issue_valid   = ($urandom_range(0, 99) < 60);
      bus.issue_type    = 2'($urandom_range(0, 3));
      bus.issue_rd      = 5'($urandom_range(0, 31));
      bus.wb_valid      = ($urandom_range(0, 99) < wb_pct);
      bus.wb_value      = $urandom;
      bus.wb_mispredict = ($urandom_range(0, 9) == 0);
      bus.wb_target     = $urandom;
      if (rob_q.size() > 0 && $urandom_range(0, 9) != 0) begin
        k = $urandom_range(0, rob_q.size() - 1);
        bus.wb_entry = ROB_BIT'(rob_q[k].idx);
      end else begin
        bus.wb_entry = ROB_BIT'($urandom_range(0, DEPTH - 1));
      end
      bus.get_rob_entry1 = ROB_BIT'($urandom_range(0, DEPTH - 1));
      bus.get_rob_entry2 = ROB_BIT'($urandom_range(0, DEPTH - 1));
      if (cyc == 1500) begin
        rdy_in = 1'b1;
        idle();
        if (rob_q.size() > 0) bus.get_rob_entry1 = ROB_BIT'(rob_q[0].idx);
        rst_in = 1'b1;
        model_reset();
        #1;
        check("mid_rst_head", 32'(bus.head_entry), 32'd0);
        check("mid_rst_issue_entry", 32'(bus.issue_entry), 32'd0);
        check("mid_rst_ready1", 32'(bus.ready1), 32'd0);
        check("mid_rst_pulses", 32'({bus.rob_commit_reg, bus.commit_store, bus.rob_clear_up}), 32'd0);
        check("mid_rst_commit_data", bus.commit_reg_data, 32'd0);
        check("mid_rst_clear_pc", bus.clear_pc, 32'd0);
        tick();
        rst_in = 1'b0;
      end
      tick();
    end
    rdy_in = 1'b1;
    idle();
    tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
